// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared types and constants for the countdown_decrementor block.
//   state_e       : controller state (IDLE waits for a load, COUNT decrements)
//   DEFAULT_WIDTH : default counter / load-value width in bits
// -----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage : countdown_pkg

// File: rtl/decrementor.sv
// -----------------------------------------------------------------------------
// decrementor
// Purely combinational WIDTH-bit decrementor: {borrow, out} = {1'b0, in} - 1.
// The borrow bit plays the same role as the incrementor's overflow bit: it is
// set exactly when the input is all zeros and the result wraps to all ones.
// Ports:
//   in     : operand
//   out    : in - 1, modulo 2^WIDTH
//   borrow : 1 when in == 0
// -----------------------------------------------------------------------------
module decrementor #(
    parameter int WIDTH = countdown_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             borrow
);

    logic [WIDTH:0] diff;

    assign diff   = {1'b0, in} - {{WIDTH{1'b0}}, 1'b1};
    assign out    = diff[WIDTH-1:0];
    assign borrow = diff[WIDTH];

endmodule : decrementor

// File: rtl/countdown_decrementor.sv
// -----------------------------------------------------------------------------
// countdown_decrementor
// Loadable, enable-gated down-counter used as a timeout / tick counter.
//
// Load handshake (valid/ready): a load transfers on a rising clk edge where
// load_valid and load_ready are both high. load_ready is high only in IDLE and
// does not depend on load_valid. A requester that sees load_ready low must keep
// load_valid (and load_value) stable until the transfer happens.
//
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   load_valid  : load request
//   load_ready  : block can accept a load (IDLE)
//   load_value  : start value, captured on the load handshake
//   en          : decrement enable, only looked at in COUNT
//   abort       : synchronous cancel back to IDLE with out cleared
//   out         : current count (registered)
//   zero        : out == 0
//   borrow      : one-cycle pulse after an enabled decrement at out == 0
//   busy        : high in COUNT (also serves as the state debug view)
//
// Per-cycle priority: abort > load handshake > decrement.
// -----------------------------------------------------------------------------
module countdown_decrementor
    import countdown_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             borrow,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;

    logic [WIDTH-1:0] dec_out;
    logic             dec_borrow;

    decrementor #(
        .WIDTH (WIDTH)
    ) u_dec (
        .in     (out_q),
        .out    (dec_out),
        .borrow (dec_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        borrow_d = 1'b0;

        if (abort) begin
            // Cancel wins over a pending load and over an expiry this cycle.
            state_d = IDLE;
            out_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        out_d    = load_value;
                        reload_d = load_value;
                        state_d  = COUNT;
                    end
                end
                COUNT: begin
                    if (en) begin
                        if (dec_borrow) begin
                            // Expiry: the wrapped all-ones value is never stored.
                            borrow_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                out_d = reload_q;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            out_d = dec_out;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign out        = out_q;
    assign zero       = (out_q == '0);
    assign borrow     = borrow_q;
    assign busy       = (state_q == COUNT);
    assign load_ready = (state_q == IDLE);

endmodule : countdown_decrementor
